// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one operand bit per cycle, with
// sign fix-up after the unsigned core and a valid/ready result handshake.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - synchronous active-high reset
//   in_valid  - an operation is offered (op, a, b)
//   in_ready  - unit is idle and can accept an operation
//   op        - RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b      - rs1 and rs2 operands
//   flush     - pipeline kill; discards any operation in flight
//   out_valid - result is available
//   out_ready - consumer takes the result
//   result    - 32-bit result, zero whenever out_valid is low
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] bm_q;
    logic        neg_q;
    logic [63:0] prod_q;
    logic [31:0] quot_q;
    logic [31:0] rem_q;
    logic [31:0] res_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] result_q;

    // Operand decode at accept time
    logic        sgn_a;
    logic        sgn_b;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div0;
    logic        ovf;
    logic [31:0] spec_res;
    logic        res_neg;

    always_comb begin
        sgn_a    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        sgn_b    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg    = sgn_a & a[31];
        b_neg    = sgn_b & b[31];
        a_mag    = a_neg ? (~a + 32'd1) : a;
        b_mag    = b_neg ? (~b + 32'd1) : b;
        div0     = op[2] && (b == 32'd0);
        ovf      = op[2] && !op[0] && (a == 32'h8000_0000)
                   && (b == 32'hFFFF_FFFF);
        // REM/REMU take a (b=0) or 0 (overflow); DIV/DIVU all-ones or INT_MIN
        if (div0) begin
            spec_res = op[1] ? a : 32'hFFFF_FFFF;
        end else begin
            spec_res = op[1] ? 32'd0 : 32'h8000_0000;
        end
        // Remainder follows the dividend sign; everything else sign(a)^sign(b)
        res_neg  = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
    end

    // Iteration datapath
    logic [32:0] madd;
    logic [63:0] prod_d;
    logic [32:0] dsh;
    logic [33:0] ddiff;
    logic [31:0] quot_d;
    logic [31:0] rem_d;

    always_comb begin
        // Shift-add: low half holds the remaining multiplier bits
        madd   = {1'b0, prod_q[63:32]}
                 + (prod_q[0] ? {1'b0, bm_q} : 33'd0);
        prod_d = {madd, prod_q[31:1]};
        // Restoring divide: quot_q shifts dividend bits out, quotient bits in
        dsh    = {rem_q, quot_q[31]};
        ddiff  = {1'b0, dsh} - {2'b00, bm_q};
        if (!ddiff[33]) begin
            rem_d  = ddiff[31:0];
            quot_d = {quot_q[30:0], 1'b1};
        end else begin
            rem_d  = dsh[31:0];
            quot_d = {quot_q[30:0], 1'b0};
        end
    end

    // Sign fix-up and result selection
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] fix_res;

    always_comb begin
        prod_s = neg_q ? (~prod_q + 64'd1) : prod_q;
        quot_s = neg_q ? (~quot_q + 32'd1) : quot_q;
        rem_s  = neg_q ? (~rem_q + 32'd1) : rem_q;
        unique case (op_q)
            3'd0:    fix_res = prod_s[31:0];
            3'd1,
            3'd2,
            3'd3:    fix_res = prod_s[63:32];
            3'd4,
            3'd5:    fix_res = quot_s;
            default: fix_res = rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            op_q        <= 3'd0;
            bm_q        <= 32'd0;
            neg_q       <= 1'b0;
            prod_q      <= 64'd0;
            quot_q      <= 32'd0;
            rem_q       <= 32'd0;
            res_q       <= 32'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q       <= op;
                        bm_q       <= b_mag;
                        neg_q      <= res_neg;
                        prod_q     <= {32'd0, a_mag};
                        quot_q     <= a_mag;
                        rem_q      <= 32'd0;
                        cnt_q      <= 5'd0;
                        in_ready_q <= 1'b0;
                        if (div0 || ovf) begin
                            res_q   <= spec_res;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        quot_q <= quot_d;
                        rem_q  <= rem_d;
                    end else begin
                        prod_q <= prod_d;
                    end
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    res_q   <= fix_res;
                    state_q <= DONE;
                end
                DONE: begin
                    // out_valid rises one cycle after entering DONE
                    if (out_valid_q && out_ready) begin
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        result_q    <= 32'd0;
                    end else if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        result_q    <= res_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv: hand-computed RV32M vectors, latency,
// back-pressure, flush and reset abort checks.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int checks;
    int failures;

    ex_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept an operation, wait for out_valid, check latency/result/handshake
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int lat);
        int n;
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_res"}, result, exp);
        tick();
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_clr"}, {31'd0, out_valid}, 32'd0);
    endtask

    // Count out_valid highs over a window
    task automatic quiet(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (out_valid) hits++;
        end
        chk(tag, hits, 0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 3'd0;
        a         = 32'd0;
        b         = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;
        tick();

        // Multiply family
        run_op("mul_7x6", 3'd0, 32'd7, 32'd6, 32'd42, 35);
        run_op("mul_big", 3'd0, 32'h1234_5678, 32'd9, 32'hA3D7_0A38, 35);
        run_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 35);
        run_op("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 35);
        run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 35);

        // Divide family
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
        run_op("div_7_m2", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35);
        run_op("rem_7_m2", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 35);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 35);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 35);

        // Special cases
        run_op("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("remu_z", 3'd7, 32'd5, 32'd0, 32'd5, 2);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 2);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

        // Back-pressure: hold out_ready low, pulse in_valid meanwhile
        out_ready = 1'b0;
        op        = 3'd5;
        a         = 32'd100;
        b         = 32'd7;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 100 && !out_valid; i++) tick();
        chk("stall_valid0", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            op       = 3'd0;
            a        = 32'd1;
            b        = 32'd1;
            in_valid = (i % 2) == 0;
            tick();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_res", result, 32'd14);
            chk("stall_nordy", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_rel_rdy", {31'd0, in_ready}, 32'd1);
        chk("stall_rel_res", result, 32'd0);
        quiet("stall_no_extra", 40);

        // Flush at CALC count 10
        op       = 3'd0;
        a        = 32'd3;
        b        = 32'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_rdy", {31'd0, in_ready}, 32'd1);
        chk("flush_ov", {31'd0, out_valid}, 32'd0);
        quiet("flush_quiet", 40);

        // Reset at CALC count 20
        op       = 3'd5;
        a        = 32'd50;
        b        = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_rdy", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_ov", {31'd0, out_valid}, 32'd0);
        quiet("rst_mid_quiet", 40);

        // Flush beats in_valid in IDLE
        op       = 3'd5;
        a        = 32'd5;
        b        = 32'd0;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_iv_rdy", {31'd0, in_ready}, 32'd1);
        quiet("flush_iv_quiet", 10);

        // Unit still works afterwards
        run_op("post_mul", 3'd0, 32'd11, 32'd13, 32'd143, 35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
